// File: rtl/fault_mem_cfg_if.sv
// Command, read-back and fault-table configuration bundle for the faulty SRAM model.
// The master drives commands and configuration; the slave (memory model) drives results.
interface fault_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_FAULTS = 4,
  parameter int BIT_W      = $clog2(DATA_WIDTH),
  parameter int SLOT_W     = $clog2(NUM_FAULTS)
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  logic                  cfg_we;
  logic [SLOT_W-1:0]     cfg_slot;
  logic [2:0]            cfg_type;
  logic [ADDR_WIDTH-1:0] cfg_vaddr;
  logic [BIT_W-1:0]      cfg_vbit;
  logic [ADDR_WIDTH-1:0] cfg_aaddr;
  logic [BIT_W-1:0]      cfg_abit;
  logic                  cfg_val;
  logic [1:0]            cfg_pat;

  logic                  fault_hit;
  logic [15:0]           fault_cnt;

  modport master (
    output write_read, address, wdata,
    output cfg_we, cfg_slot, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit, cfg_val, cfg_pat,
    input  rdata, rvalid, fault_hit, fault_cnt
  );

  modport slave (
    input  write_read, address, wdata,
    input  cfg_we, cfg_slot, cfg_type, cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit, cfg_val, cfg_pat,
    output rdata, rvalid, fault_hit, fault_cnt
  );
endinterface

// File: rtl/fault_mem_cfg.sv
// Faulty SRAM model with a runtime-programmable fault table, 2-cycle read latency
// and a saturating count of writes that a fault altered.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int NUM_FAULTS = 4,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input logic        clk,
  input logic        rst_n,
  fault_mem_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_SA   = 3'd1,
    FT_TF   = 3'd2,
    FT_CFID = 3'd3,
    FT_CFST = 3'd4,
    FT_NPSF = 3'd5
  } fault_e;

  fault_e                r_type  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] r_vaddr [NUM_FAULTS];
  logic [BIT_W-1:0]      r_vbit  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] r_aaddr [NUM_FAULTS];
  logic [BIT_W-1:0]      r_abit  [NUM_FAULTS];
  logic [1:0]            r_pat   [NUM_FAULTS];
  logic [NUM_FAULTS-1:0] r_val;

  logic                  r_stg_vld;
  logic                  r_stg_we;
  logic [ADDR_WIDTH-1:0] r_stg_addr;
  logic [DATA_WIDTH-1:0] r_stg_data;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_word;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_hit;
  logic [15:0]           r_cnt;

  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_nb_up;
  logic [DATA_WIDTH-1:0] w_nb_dn;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [NUM_FAULTS-1:0] w_cfid_fire;
  logic                  w_commit_wr;
  logic                  w_commit_rd;
  logic                  w_hit;

  // Unsupported type codes (6, 7) are folded to NONE when the slot is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_FAULTS; s++) begin
        r_type[s]  <= FT_NONE;
        r_vaddr[s] <= '0;
        r_vbit[s]  <= '0;
        r_aaddr[s] <= '0;
        r_abit[s]  <= '0;
        r_pat[s]   <= '0;
      end
      r_val <= '0;
    end else if (bus.cfg_we) begin
      r_type[bus.cfg_slot]  <= (bus.cfg_type > 3'd5) ? FT_NONE : fault_e'(bus.cfg_type);
      r_vaddr[bus.cfg_slot] <= bus.cfg_vaddr;
      r_vbit[bus.cfg_slot]  <= bus.cfg_vbit;
      r_aaddr[bus.cfg_slot] <= bus.cfg_aaddr;
      r_abit[bus.cfg_slot]  <= bus.cfg_abit;
      r_pat[bus.cfg_slot]   <= bus.cfg_pat;
      r_val[bus.cfg_slot]   <= bus.cfg_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld  <= 1'b0;
      r_stg_we   <= 1'b0;
      r_stg_addr <= '0;
      r_stg_data <= '0;
    end else begin
      r_stg_vld  <= 1'b1;
      r_stg_we   <= bus.write_read;
      r_stg_addr <= bus.address;
      r_stg_data <= bus.wdata;
    end
  end

  assign w_commit_wr = r_stg_vld &  r_stg_we;
  assign w_commit_rd = r_stg_vld & ~r_stg_we;
  assign w_old       = r_mem[r_stg_addr];
  assign w_nb_up     = r_mem[r_stg_addr + ADDR_ONE];
  assign w_nb_dn     = r_mem[r_stg_addr - ADDR_ONE];

  // Slots are applied in index order so a higher slot overrides a lower one on the
  // same bit; TF looks at the word as already modified by earlier slots.
  always_comb begin
    w_wr_word   = r_stg_data;
    w_rd_word   = w_old;
    w_cfid_fire = '0;
    for (int s = 0; s < NUM_FAULTS; s++) begin
      case (r_type[s])
        FT_SA: begin
          if (r_vaddr[s] == r_stg_addr) begin
            w_wr_word[r_vbit[s]] = r_val[s];
            w_rd_word[r_vbit[s]] = r_val[s];
          end
        end
        FT_TF: begin
          if ((r_vaddr[s] == r_stg_addr) && (w_old[r_vbit[s]] != r_val[s]) &&
              (w_wr_word[r_vbit[s]] == r_val[s]))
            w_wr_word[r_vbit[s]] = ~r_val[s];
        end
        FT_CFID: begin
          w_cfid_fire[s] = (r_aaddr[s] == r_stg_addr) && (r_aaddr[s] != r_vaddr[s]) &&
                           (w_old[r_abit[s]] != r_stg_data[r_abit[s]]) &&
                           (r_stg_data[r_abit[s]] == r_val[s]);
        end
        FT_CFST: begin
          if ((r_vaddr[s] == r_stg_addr) && (r_mem[r_aaddr[s]][r_abit[s]] == r_pat[s][0]))
            w_wr_word[r_vbit[s]] = r_val[s];
        end
        FT_NPSF: begin
          if ((r_vaddr[s] == r_stg_addr) &&
              ({w_nb_up[r_vbit[s]], w_nb_dn[r_vbit[s]]} == r_pat[s]))
            w_wr_word[r_vbit[s]] = r_val[s];
        end
        default: ;
      endcase
    end
  end

  assign w_hit = w_commit_wr && ((w_wr_word != r_stg_data) || (|w_cfid_fire));

  // CFID victims never share the written address (aggressor != victim), so the
  // bit flips and the word write cannot collide.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      for (int s = 0; s < NUM_FAULTS; s++) begin
        if (w_cfid_fire[s])
          r_mem[r_vaddr[s]][r_vbit[s]] <= ~r_mem[r_vaddr[s]][r_vbit[s]];
      end
      r_mem[r_stg_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_word <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_hit     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rd_vld  <= w_commit_rd;
      r_rd_word <= w_rd_word;
      r_rvalid  <= r_rd_vld;
      if (r_rd_vld)
        r_rdata <= r_rd_word;
      r_hit <= w_hit;
      if (w_hit && (r_cnt != 16'hFFFF))
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.rvalid    = r_rvalid;
  assign bus.fault_hit = r_hit;
  assign bus.fault_cnt = r_cnt;

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Directed and randomized bench for fault_mem_cfg against a transaction-level
// reference model of the fault table and memory array.
module tb_fault_mem_cfg;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FAULTS(NF)) bus ();

  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(64), .NUM_FAULTS(NF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [64];
  int         m_type [NF];
  int         m_va [NF], m_vb [NF], m_aa [NF], m_ab [NF];
  logic       m_val [NF];
  logic [1:0] m_pat [NF];

  bit         p_vld, p_we;
  int         p_addr;
  logic [7:0] p_data;
  bit         q_vld;
  logic [7:0] q_data;
  logic [7:0] e_rdata;
  bit         e_rvalid, e_hit;
  int         e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NF; s++) m_type[s] = 0;
    p_vld = 0; q_vld = 0;
    e_rdata = 8'h00; e_rvalid = 0; e_hit = 0; e_cnt = 0;
  endtask

  function automatic logic [7:0] read_view(int a);
    logic [7:0] r;
    r = m_mem[a];
    for (int s = 0; s < NF; s++)
      if (m_type[s] == 1 && m_va[s] == a) r[m_vb[s]] = m_val[s];
    return r;
  endfunction

  task automatic commit_write(int a, logic [7:0] d);
    logic [7:0] old, w;
    logic [7:0] nxt [64];
    bit any;
    old = m_mem[a]; w = d; any = 0; nxt = m_mem;
    for (int s = 0; s < NF; s++) begin
      case (m_type[s])
        1: if (m_va[s] == a) w[m_vb[s]] = m_val[s];
        2: if (m_va[s] == a) begin
             if (m_val[s] == 1'b1 && old[m_vb[s]] == 1'b0 && w[m_vb[s]] == 1'b1) w[m_vb[s]] = 1'b0;
             else if (m_val[s] == 1'b0 && old[m_vb[s]] == 1'b1 && w[m_vb[s]] == 1'b0) w[m_vb[s]] = 1'b1;
           end
        3: if (m_aa[s] == a && m_aa[s] != m_va[s] && old[m_ab[s]] != d[m_ab[s]] && d[m_ab[s]] == m_val[s]) begin
             nxt[m_va[s]][m_vb[s]] = ~m_mem[m_va[s]][m_vb[s]];
             any = 1;
           end
        4: if (m_va[s] == a && m_mem[m_aa[s]][m_ab[s]] == m_pat[s][0]) w[m_vb[s]] = m_val[s];
        5: if (m_va[s] == a &&
               {m_mem[(a + 1) % 64][m_vb[s]], m_mem[(a + 63) % 64][m_vb[s]]} == m_pat[s])
             w[m_vb[s]] = m_val[s];
        default: ;
      endcase
    end
    nxt[a] = w;
    m_mem = nxt;
    if (w != d || any) begin
      e_hit = 1;
      if (e_cnt < 65535) e_cnt++;
    end
  endtask

  task automatic model_edge();
    e_rvalid = q_vld;
    if (q_vld) e_rdata = q_data;
    e_hit = 0;
    q_vld = 0;
    if (p_vld) begin
      if (p_we) commit_write(p_addr, p_data);
      else begin q_vld = 1; q_data = read_view(p_addr); end
    end
    if (bus.cfg_we) begin
      m_type[bus.cfg_slot] = (bus.cfg_type > 3'd5) ? 0 : int'(bus.cfg_type);
      m_va[bus.cfg_slot]   = int'(bus.cfg_vaddr);
      m_vb[bus.cfg_slot]   = int'(bus.cfg_vbit);
      m_aa[bus.cfg_slot]   = int'(bus.cfg_aaddr);
      m_ab[bus.cfg_slot]   = int'(bus.cfg_abit);
      m_val[bus.cfg_slot]  = bus.cfg_val;
      m_pat[bus.cfg_slot]  = bus.cfg_pat;
    end
    p_vld = 1; p_we = bus.write_read; p_addr = int'(bus.address); p_data = bus.wdata;
  endtask

  task automatic step(input logic we, input int a, input logic [7:0] d);
    bus.write_read = we;
    bus.address    = 6'(a);
    bus.wdata      = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
    chk("rdata", 32'(bus.rdata), 32'(e_rdata));
    chk("fault_hit", 32'(bus.fault_hit), 32'(e_hit));
    chk("fault_cnt", 32'(bus.fault_cnt), 32'(e_cnt));
  endtask

  task automatic rd_expect(input int a, input logic [7:0] exp, input string tag);
    step(1'b0, a, 8'h00);
    step(1'b0, 0, 8'h00);
    step(1'b0, 0, 8'h00);
    chk(tag, 32'(bus.rdata), 32'(exp));
    chk({tag, "_valid"}, 32'(bus.rvalid), 32'd1);
  endtask

  task automatic set_slot(input int slot, input int typ, input int va, input int vb,
                          input int aa, input int ab, input logic val, input logic [1:0] pat);
    bus.cfg_slot = 2'(slot); bus.cfg_type = 3'(typ);
    bus.cfg_vaddr = 6'(va); bus.cfg_vbit = 3'(vb);
    bus.cfg_aaddr = 6'(aa); bus.cfg_abit = 3'(ab);
    bus.cfg_val = val; bus.cfg_pat = pat;
    bus.cfg_we = 1'b1;
    step(1'b0, 0, 8'h00);
    bus.cfg_we = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    chk("rst_cnt", 32'(bus.fault_cnt), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) != 0) return ($urandom_range(0, 5) + 62) % 64;
    return $urandom_range(0, 63);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_read = 1'b0; bus.address = '0; bus.wdata = '0;
    bus.cfg_we = 1'b0; bus.cfg_slot = '0; bus.cfg_type = '0;
    bus.cfg_vaddr = '0; bus.cfg_vbit = '0; bus.cfg_aaddr = '0; bus.cfg_abit = '0;
    bus.cfg_val = 1'b0; bus.cfg_pat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 32'(bus.rdata), 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_hit", 32'(bus.fault_hit), 32'd0);
    chk("reset_cnt", 32'(bus.fault_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) step(1'b1, i, 8'(i * 7 + 1));

    // 1: write in flight when reset hits is dropped
    step(1'b1, 5, 8'h33);
    rst_pulse();
    rd_expect(5, 8'h24, "t1_dropped");
    step(1'b1, 5, 8'hA5);
    rd_expect(5, 8'hA5, "t1_read");
    chk("t1_cnt", 32'(bus.fault_cnt), 32'd0);

    // 2: stuck-at-1
    set_slot(0, 1, 10, 3, 0, 0, 1'b1, 2'b00);
    step(1'b1, 10, 8'h00);
    step(1'b0, 0, 8'h00);
    chk("t2_hit", 32'(bus.fault_hit), 32'd1);
    chk("t2_cnt", 32'(bus.fault_cnt), 32'd1);
    rd_expect(10, 8'h08, "t2_read0");
    step(1'b1, 10, 8'hFF);
    rd_expect(10, 8'hFF, "t2_readff");
    chk("t2_cnt_hold", 32'(bus.fault_cnt), 32'd1);

    // 3: rising transition fault, then cleared by reset
    set_slot(1, 2, 20, 0, 0, 0, 1'b1, 2'b00);
    step(1'b1, 20, 8'h00);
    step(1'b1, 20, 8'h01);
    step(1'b0, 0, 8'h00);
    chk("t3_cnt", 32'(bus.fault_cnt), 32'd2);
    rd_expect(20, 8'h00, "t3_tf");
    rst_pulse();
    step(1'b1, 20, 8'h01);
    rd_expect(20, 8'h01, "t3_cleared");

    // 4: idempotent coupling, rising aggressor
    set_slot(0, 3, 31, 2, 30, 7, 1'b1, 2'b00);
    step(1'b1, 31, 8'h00);
    step(1'b1, 30, 8'h00);
    step(1'b1, 30, 8'h80);
    rd_expect(31, 8'h04, "t4_cfid");
    step(1'b1, 30, 8'h80);
    rd_expect(31, 8'h04, "t4_no_transition");
    chk("t4_cnt", 32'(bus.fault_cnt), 32'd1);

    // 5: NPSF at address 0 with wrapped neighbour 63
    set_slot(1, 5, 0, 1, 0, 0, 1'b1, 2'b10);
    step(1'b1, 1, 8'h02);
    step(1'b1, 63, 8'h00);
    step(1'b1, 0, 8'h00);
    rd_expect(0, 8'h02, "t5_npsf");
    step(1'b1, 1, 8'h00);
    step(1'b1, 0, 8'h00);
    rd_expect(0, 8'h00, "t5_no_pattern");
    chk("t5_cnt", 32'(bus.fault_cnt), 32'd2);

    // 6: higher slot wins; read right behind the write
    rst_pulse();
    set_slot(0, 1, 12, 3, 0, 0, 1'b0, 2'b00);
    set_slot(2, 1, 12, 3, 0, 0, 1'b1, 2'b00);
    step(1'b1, 12, 8'h55);
    rd_expect(12, 8'h5D, "t6_priority");

    rst_pulse();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.cfg_slot  = 2'($urandom_range(0, 3));
        bus.cfg_type  = 3'($urandom_range(0, 7));
        bus.cfg_vaddr = 6'(pick_addr());
        bus.cfg_vbit  = 3'($urandom_range(0, 7));
        bus.cfg_aaddr = 6'(pick_addr());
        bus.cfg_abit  = 3'($urandom_range(0, 7));
        bus.cfg_val   = 1'($urandom_range(0, 1));
        bus.cfg_pat   = 2'($urandom_range(0, 3));
        bus.cfg_we    = 1'b1;
      end
      step(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
      bus.cfg_we = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
